// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: CPU-side and memory-side handshake bundle for cache_ctrl.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> controller; cpu_rdata/cpu_ready <- controller
//   mem_req/mem_we/mem_addr/mem_wdata <- controller; mem_rdata/mem_ready -> controller
// slave modport is the controller view, master is the CPU+memory environment view.
interface cache_ctrl_if #(
  parameter int TAG           = 20,
  parameter int INDEX         = 8,
  parameter int DATA_BLOCK    = 128,
  parameter int WORD_SIZE_BIT = 32
);
  localparam int AW = TAG + INDEX + 4;

  logic                     cpu_req;
  logic                     cpu_we;
  logic [AW-1:0]            cpu_addr;
  logic [WORD_SIZE_BIT-1:0] cpu_wdata;
  logic [WORD_SIZE_BIT-1:0] cpu_rdata;
  logic                     cpu_ready;
  logic                     mem_req;
  logic                     mem_we;
  logic [AW-1:0]            mem_addr;
  logic [DATA_BLOCK-1:0]    mem_wdata;
  logic [DATA_BLOCK-1:0]    mem_rdata;
  logic                     mem_ready;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-back, write-allocate cache controller.
// Holds tag/valid/dirty/block arrays and sequences lookup, dirty writeback
// and block refill. All outputs registered.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears valid/dirty, returns to IDLE
//   bus   : cache_ctrl_if.slave (CPU word port + 128-bit block memory port)
module cache_ctrl #(
  parameter int TAG           = 20,
  parameter int INDEX         = 8,
  parameter int DATA_BLOCK    = 128,
  parameter int WORD_SIZE_BIT = 32
) (
  input  logic          clk,
  input  logic          reset,
  cache_ctrl_if.slave   bus
);
  localparam int AW    = TAG + INDEX + 4;
  localparam int LINES = 1 << INDEX;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  typedef struct packed {
    logic                     we;
    logic [AW-1:0]            addr;
    logic [WORD_SIZE_BIT-1:0] wdata;
  } req_t;

  state_t state, state_nxt;
  req_t   req;

  logic [TAG-1:0]        tag_arr  [LINES];
  logic [DATA_BLOCK-1:0] data_arr [LINES];
  logic [LINES-1:0]      valid, dirty;

  logic [TAG-1:0]           req_tag;
  logic [INDEX-1:0]         req_idx;
  logic [1:0]               req_wsel;
  logic [TAG-1:0]           old_tag;
  logic [DATA_BLOCK-1:0]    old_blk;
  logic [DATA_BLOCK-1:0]    wr_blk;
  logic [WORD_SIZE_BIT-1:0] rd_word;
  logic                     hit;
  logic                     mem_ack;

  assign req_tag  = req.addr[AW-1 -: TAG];
  assign req_idx  = req.addr[INDEX+3:4];
  assign req_wsel = req.addr[3:2];
  assign old_tag  = tag_arr[req_idx];
  assign old_blk  = data_arr[req_idx];
  assign hit      = valid[req_idx] && (old_tag == req_tag);
  // mem_ready only counts while a request is actually outstanding
  assign mem_ack  = bus.mem_req && bus.mem_ready;

  always_comb begin
    wr_blk = old_blk;
    wr_blk[req_wsel*WORD_SIZE_BIT +: WORD_SIZE_BIT] = req.wdata;
    rd_word = old_blk[req_wsel*WORD_SIZE_BIT +: WORD_SIZE_BIT];
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (bus.cpu_req) state_nxt = COMPARE;
      COMPARE:   if (hit)                              state_nxt = IDLE;
                 else if (valid[req_idx] && dirty[req_idx]) state_nxt = WRITEBACK;
                 else                                  state_nxt = ALLOCATE;
      WRITEBACK: if (mem_ack) state_nxt = ALLOCATE;
      ALLOCATE:  if (mem_ack) state_nxt = COMPARE;
      default:   state_nxt = IDLE;
    endcase
  end

  // registered outputs, request latch, valid/dirty bits
  always_ff @(posedge clk) begin
    if (reset) begin
      req           <= '0;
      valid         <= '0;
      dirty         <= '0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.cpu_ready <= 1'b0;
      case (state)
        IDLE: if (bus.cpu_req) req <= '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
        COMPARE: begin
          if (hit) begin
            if (req.we) dirty[req_idx] <= 1'b1;
            else        bus.cpu_rdata  <= rd_word;
            bus.cpu_ready <= 1'b1;
          end else if (valid[req_idx] && dirty[req_idx]) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= {old_tag, req_idx, 4'b0};
            bus.mem_wdata <= old_blk;
          end else begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {req_tag, req_idx, 4'b0};
          end
        end
        WRITEBACK: if (mem_ack) begin
          // roll straight into the refill request; mem_req stays high
          bus.mem_we   <= 1'b0;
          bus.mem_addr <= {req_tag, req_idx, 4'b0};
        end
        ALLOCATE: if (mem_ack) begin
          valid[req_idx] <= 1'b1;
          dirty[req_idx] <= 1'b0;
          bus.mem_req    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // tag/data storage: contents are don't-care after reset, so no clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == COMPARE && hit && req.we)
        data_arr[req_idx] <= wr_blk;
      if (state == ALLOCATE && mem_ack) begin
        data_arr[req_idx] <= bus.mem_rdata;
        tag_arr[req_idx]  <= req_tag;
      end
    end
  end
endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, write-back, write-allocate cache controller that sits in front of the tag comparator and word-select mux. It holds the tag/valid/dirty and block arrays and sequences lookup, dirty-block writeback and block refill. Each CPU word request resolves to one `cpu_ready` pulse, and main memory is accessed one 128-bit block at a time.

## Interface
- `TAG`, 20: tag width; address = {tag, index, 4-bit byte offset}.
- `INDEX`, 8: index width; 2^INDEX lines.
- `DATA_BLOCK`, 128: line width (4 words).
- `WORD_SIZE_BIT`, 32: CPU word width.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: request strobe, sampled only in IDLE.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in TAG+INDEX+4: byte address; bits [3:2] select the word, bits [1:0] are ignored.
- `cpu_wdata` in WORD_SIZE_BIT: write data.
- `cpu_rdata` out WORD_SIZE_BIT: read data, valid while `cpu_ready`=1.
- `cpu_ready` out 1: one-cycle completion pulse.
- `mem_req` out 1: memory request, held until `mem_ready`.
- `mem_we` out 1: 1 = block write (writeback), 0 = block read (refill).
- `mem_addr` out TAG+INDEX+4: block address, low 4 bits always 0.
- `mem_wdata` out DATA_BLOCK: writeback block.
- `mem_rdata` in DATA_BLOCK: refill block, valid with `mem_ready`.
- `mem_ready` in 1: memory completion, sampled only while `mem_req`=1.

## Operation
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- **IDLE**
  - If `cpu_req`=1, latch `cpu_we`, `cpu_addr` and `cpu_wdata`, then go to COMPARE.
  - Inputs are ignored in every other state.
- **COMPARE**
  - Hit = `valid[index]` && `tag[index]` == latched tag.
  - Read hit: `cpu_rdata` <= word [3:2] of the block; `cpu_ready` <= 1; go to IDLE.
  - Write hit: replace word [3:2] in the block; `dirty[index]` <= 1; `cpu_ready` <= 1; go to IDLE.
  - Miss with valid and dirty line: go to WRITEBACK with `mem_req`=1, `mem_we`=1, `mem_addr`={old tag, index, 4'b0}, `mem_wdata`=old block.
  - Miss otherwise: go to ALLOCATE with `mem_req`=1, `mem_we`=0, `mem_addr`={latched tag, index, 4'b0}.
- **WRITEBACK**
  - Hold all `mem_*` outputs until `mem_ready`=1.
  - Then go to ALLOCATE: `mem_we` <= 0, `mem_addr` <= refill address, `mem_req` stays 1.
- **ALLOCATE**
  - On `mem_ready`=1: block <= `mem_rdata`, tag <= latched tag, valid <= 1, dirty <= 0, `mem_req` <= 0, go to COMPARE.
  - The re-compare then hits and completes as above.
- Reset clears every valid and dirty bit; tag and data contents are don't-care.

## Timing
- **Reset values:** state IDLE; `cpu_ready`=0, `cpu_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **Registered outputs:** all outputs are registered; no combinational path from any input to any output.
- **Hit latency:** `cpu_req` sampled at edge N, `cpu_ready`=1 during cycle N+2.
- **Back-to-back hits:** a new `cpu_req` is accepted in the same cycle `cpu_ready` is high, giving one request per 2 cycles.
- **Miss latency:** 2 + (cycles to `mem_ready` per memory access) + 1 re-compare cycle.
- **`cpu_ready`:** exactly one cycle per request; never asserted in WRITEBACK or ALLOCATE.
- **`mem_req` protocol:** `mem_req` never drops before `mem_ready`. A `mem_ready` arriving with `mem_req`=0 is ignored.
- **Writeback to refill:** `mem_ready` in WRITEBACK is followed immediately by the ALLOCATE request with no idle cycle between them.
- **Reset mid-operation:** state goes to IDLE, `mem_req` is 0 the cycle after reset, and the pending request is dropped with no `cpu_ready`.
- **Same-index conflict:** two addresses with the same index but different tags evict each other. Every eviction of a dirty line produces a writeback.

## Test plan
- **Cold read miss:** reset, then read 0x0000_1234 -> ALLOCATE with `mem_addr`=0x0000_1230, `mem_we`=0. Memory returns 0xDDDD…_CCCC…_BBBB…_AAAA… -> `cpu_rdata`=word[1] (0xBBBBBBBB) with a single `cpu_ready` pulse.
- **Write hit then read:** write 0xCAFEF00D to 0x0000_1238 -> `cpu_ready` 2 cycles after `cpu_req`, no `mem_req`. Read 0x0000_1238 -> 0xCAFEF00D.
- **Dirty eviction:** after the write above, read 0x0001_1230 (same index) -> WRITEBACK with `mem_addr`=0x0000_1230 and `mem_wdata` containing 0xCAFEF00D in word[2]. Then ALLOCATE at 0x0001_1230 with no gap.
- **Memory stalls:** `mem_ready` delayed 7 cycles -> `mem_req`, `mem_addr` and `mem_wdata` stable throughout; exactly one transfer occurs.
- **Reset mid-refill:** assert `reset` during ALLOCATE -> next cycle `mem_req`=0 and `cpu_ready`=0. A read of the same address afterwards misses again because valid was cleared.
- **Back-to-back hits:** 4 reads to a resident line on consecutive accept opportunities -> `cpu_ready` on every 2nd cycle with the correct words 0..3.
